// File: rtl/uart_reg_bridge.sv
// Host-command register bridge between a UART byte stream and the R-peak core: sample FIFO in, peak FIFO out.
// Optional write-data timeout is enabled by defining UART_BRIDGE_TIMEOUT_EN.
module uart_reg_bridge #(
  parameter int DATA_WIDTH        = 11,
  parameter int CTR_WIDTH         = 22,
  parameter int SAMPLE_FIFO_DEPTH = 16,
  parameter int PEAK_FIFO_DEPTH   = 8,
  parameter int TIMEOUT_CYCLES    = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] sample_data,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  input  logic                  peak_valid,
  input  logic [CTR_WIDTH-1:0]  peak_location,
  output logic                  ce
);

  // Handshakes: a byte moves on rx_valid & rx_ready, a response on tx_valid & tx_ready,
  // a sample on sample_valid & sample_ready; valid never waits on ready.

  localparam int SAW = $clog2(SAMPLE_FIFO_DEPTH);
  localparam int PAW = $clog2(PEAK_FIFO_DEPTH);

  localparam logic [2:0] A_CR    = 3'd0;
  localparam logic [2:0] A_SR    = 3'd1;
  localparam logic [2:0] A_DINL  = 3'd2;
  localparam logic [2:0] A_DINH  = 3'd3;
  localparam logic [2:0] A_DOUTL = 3'd4;
  localparam logic [2:0] A_DOUTM = 3'd5;
  localparam logic [2:0] A_DOUTH = 3'd6;

  typedef enum logic [1:0] {IDLE, WDATA, RESP} state_t;

  state_t     state;
  logic [2:0] addr_q;
  logic       en;
  logic [7:0] dinl;
  logic       samp_ovf;
  logic       peak_ovf;
  logic       to_flag;
  logic       to_hit;

  logic cmd_acc, rd_cmd, wr_acc, cr_wr, flush, dinl_wr, dinh_wr, en_n;

  assign ce      = en;
  assign cmd_acc = (state == IDLE) && rx_valid && (rx_data[7:4] == 4'h0);
  assign rd_cmd  = cmd_acc && !rx_data[0];
  assign wr_acc  = (state == WDATA) && rx_valid;
  assign cr_wr   = wr_acc && (addr_q == A_CR);
  assign flush   = cr_wr && rx_data[1];
  assign dinl_wr = wr_acc && (addr_q == A_DINL);
  assign dinh_wr = wr_acc && (addr_q == A_DINH);
  assign en_n    = cr_wr ? rx_data[0] : en;

  // ---------------- sample FIFO ----------------
  logic [DATA_WIDTH-1:0] s_mem [SAMPLE_FIFO_DEPTH];
  logic [SAW-1:0]        s_wr, s_rd, s_rd_n;
  logic [SAW:0]          s_cnt, s_cnt_n;
  logic                  s_full, s_empty, s_pop, s_push, s_ovf_set;
  logic [DATA_WIDTH-1:0] s_wdata, s_head_n;

  assign s_full    = s_cnt[SAW];
  assign s_empty   = (s_cnt == '0);
  assign s_wdata   = {rx_data[DATA_WIDTH-9:0], dinl};
  assign s_pop     = sample_valid && sample_ready;
  assign s_push    = dinh_wr && (!s_full || s_pop);
  assign s_ovf_set = dinh_wr && s_full && !s_pop;

  always_comb begin
    s_cnt_n = s_cnt;
    s_rd_n  = s_rd;
    if (flush) begin
      s_cnt_n = '0;
      s_rd_n  = '0;
    end else begin
      if (s_pop) s_rd_n = s_rd + 1'b1;
      if (s_push && !s_pop) s_cnt_n = s_cnt + 1'b1;
      else if (!s_push && s_pop) s_cnt_n = s_cnt - 1'b1;
    end
  end

  // Output register holds the post-edge head, so a sample written into an empty slot bypasses memory.
  always_comb begin
    s_head_n = s_mem[s_rd_n];
    if (s_push && (s_wr == s_rd_n)) s_head_n = s_wdata;
  end

  always_ff @(posedge clk) begin
    if (s_push && !flush) s_mem[s_wr] <= s_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_wr         <= '0;
      s_rd         <= '0;
      s_cnt        <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
    end else begin
      if (flush) s_wr <= '0;
      else if (s_push) s_wr <= s_wr + 1'b1;
      s_rd         <= s_rd_n;
      s_cnt        <= s_cnt_n;
      sample_valid <= (s_cnt_n != '0) && en_n;
      sample_data  <= s_head_n;
    end
  end

  // ---------------- peak FIFO ----------------
  logic [CTR_WIDTH-1:0] p_mem [PEAK_FIFO_DEPTH];
  logic [PAW-1:0]       p_wr, p_rd;
  logic [PAW:0]         p_cnt;
  logic                 p_full, p_empty, p_pop, p_push, p_ovf_set;
  logic [23:0]          head_ext;

  assign p_full    = p_cnt[PAW];
  assign p_empty   = (p_cnt == '0);
  assign p_pop     = rd_cmd && (rx_data[3:1] == A_DOUTH) && !p_empty;
  assign p_push    = peak_valid && (!p_full || p_pop);
  assign p_ovf_set = peak_valid && p_full && !p_pop;
  assign head_ext  = 24'(p_mem[p_rd]);

  always_ff @(posedge clk) begin
    if (p_push && !flush) p_mem[p_wr] <= peak_location;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      p_wr  <= '0;
      p_rd  <= '0;
      p_cnt <= '0;
    end else begin
      if (p_push) p_wr <= p_wr + 1'b1;
      if (p_pop) p_rd <= p_rd + 1'b1;
      if (p_push && !p_pop) p_cnt <= p_cnt + 1'b1;
      else if (!p_push && p_pop) p_cnt <= p_cnt - 1'b1;
    end
  end

  // ---------------- write-data timeout ----------------
`ifdef UART_BRIDGE_TIMEOUT_EN
  logic [31:0] to_cnt;

  assign to_hit = (state == WDATA) && !rx_valid && (to_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if ((state == WDATA) && !rx_valid && !to_hit) to_cnt <= to_cnt + 1'b1;
      else to_cnt <= '0;
      if (flush) to_flag <= 1'b0;
      else if (to_hit) to_flag <= 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign to_flag = 1'b0;
`endif

  // ---------------- read data ----------------
  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'h00;
    case (rx_data[3:1])
      A_CR:    rd_data = {7'b0, en};
      A_SR:    rd_data = {to_flag, en, peak_ovf, samp_ovf, p_empty, p_full, s_empty, s_full};
      A_DINL:  rd_data = dinl;
      A_DOUTL: rd_data = p_empty ? 8'h00 : head_ext[7:0];
      A_DOUTM: rd_data = p_empty ? 8'h00 : head_ext[15:8];
      A_DOUTH: rd_data = p_empty ? 8'h00 : head_ext[23:16];
      default: rd_data = 8'h00;
    endcase
  end

  // ---------------- command FSM and registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      rx_ready <= 1'b1;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      en       <= 1'b0;
      dinl     <= 8'h00;
      samp_ovf <= 1'b0;
      peak_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_acc && rx_data[0]) begin
            addr_q <= rx_data[3:1];
            state  <= WDATA;
          end else if (rd_cmd) begin
            tx_data  <= rd_data;
            tx_valid <= 1'b1;
            rx_ready <= 1'b0;
            state    <= RESP;
          end
        end
        WDATA: begin
          if (rx_valid || to_hit) state <= IDLE;
        end
        RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      en <= en_n;
      if (dinl_wr) dinl <= rx_data;

      if (flush) begin
        samp_ovf <= 1'b0;
        peak_ovf <= 1'b0;
      end else begin
        if (s_ovf_set) samp_ovf <= 1'b1;
        if (p_ovf_set) peak_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: register access, FIFO fill/drain/overflow, flush, drop and reset cases.
// Exercises the timeout path when UART_BRIDGE_TIMEOUT_EN is defined.
module tb_uart_reg_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [10:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        peak_valid;
  logic [21:0] peak_location;
  logic        ce;

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;

  uart_reg_bridge #(
    .DATA_WIDTH(11), .CTR_WIDTH(22), .SAMPLE_FIFO_DEPTH(16),
    .PEAK_FIFO_DEPTH(8), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .peak_valid(peak_valid), .peak_location(peak_location), .ce(ce)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tx_valid && tx_ready) resp_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] v);
    send_byte({4'h0, a, 1'b1});
    send_byte(v);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    int n;
    send_byte({4'h0, a, 1'b0});
    chk("rd_latency", 32'(tx_valid), 32'd1);
    n = 0;
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    d = tx_data;
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
  endtask

  task automatic pulse_peak(input logic [21:0] loc);
    @(negedge clk);
    peak_valid    = 1'b1;
    peak_location = loc;
    @(posedge clk);
    #1;
    peak_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]  d;
    logic [10:0] exp_s;
    int          r0;

    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    sample_ready = 1'b0; peak_valid = 1'b0; peak_location = '0;
    do_reset();

    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_ce", 32'(ce), 32'd0);

    read_reg(3'd1, d); chk("sr_reset", 32'(d), 32'h0A);
    read_reg(3'd0, d); chk("cr_reset", 32'(d), 32'h00);

    // First sample
    write_reg(3'd0, 8'h01);
    write_reg(3'd2, 8'h34);
    write_reg(3'd3, 8'h05);
    @(negedge clk);
    chk("ce_on", 32'(ce), 32'd1);
    chk("first_valid", 32'(sample_valid), 32'd1);
    chk("first_data", 32'(sample_data), 32'h534);
    read_reg(3'd2, d); chk("dinl_read", 32'(d), 32'h34);
    read_reg(3'd3, d); chk("dinh_read", 32'(d), 32'h00);

    @(negedge clk);
    sample_ready = 1'b1;
    @(posedge clk); #1;
    sample_ready = 1'b0;
    @(negedge clk);
    chk("pop_empty", 32'(sample_valid), 32'd0);
    read_reg(3'd1, d); chk("sr_en_empty", 32'(d), 32'h4A);

    // Flush with enable, then overfill the sample FIFO by one
    write_reg(3'd0, 8'h03);
    for (int i = 0; i < 17; i++) begin
      write_reg(3'd2, 8'(8'h10 + i));
      write_reg(3'd3, 8'(8'hF8 | (i & 7)));
    end
    read_reg(3'd1, d); chk("sr_samp_full_ovf", 32'(d), 32'h59);
    for (int i = 0; i < 16; i++) begin
      exp_s = {3'(i & 7), 8'(8'h10 + i)};
      @(negedge clk);
      chk("drain_valid", 32'(sample_valid), 32'd1);
      chk("drain_data", 32'(sample_data), 32'(exp_s));
      sample_ready = 1'b1;
      @(posedge clk); #1;
      sample_ready = 1'b0;
    end
    @(negedge clk);
    chk("drain_done", 32'(sample_valid), 32'd0);
    read_reg(3'd1, d); chk("sr_samp_ovf_sticky", 32'(d), 32'h5A);

    // Single peak readout
    pulse_peak(22'h2ABCDE);
    read_reg(3'd1, d); chk("sr_peak_one", 32'(d), 32'h52);
    read_reg(3'd4, d); chk("doutl", 32'(d), 32'hDE);
    read_reg(3'd5, d); chk("doutm", 32'(d), 32'hBC);
    read_reg(3'd6, d); chk("douth", 32'(d), 32'h2A);
    read_reg(3'd1, d); chk("sr_peak_empty", 32'(d), 32'h5A);
    read_reg(3'd6, d); chk("douth_empty", 32'(d), 32'h00);
    read_reg(3'd4, d); chk("doutl_empty", 32'(d), 32'h00);

    // Peak FIFO overflow: nine pushes into eight entries
    for (int i = 0; i < 9; i++) pulse_peak(22'h3F0000 | 22'(i << 8) | 22'(8'h80 + i));
    read_reg(3'd1, d); chk("sr_peak_full_ovf", 32'(d), 32'h76);
    read_reg(3'd4, d); chk("peak0_l", 32'(d), 32'h80);
    read_reg(3'd5, d); chk("peak0_m", 32'(d), 32'h00);
    read_reg(3'd6, d); chk("peak0_h", 32'(d), 32'h3F);
    read_reg(3'd4, d); chk("peak1_l", 32'(d), 32'h81);
    read_reg(3'd5, d); chk("peak1_m", 32'(d), 32'h01);
    read_reg(3'd6, d); chk("peak1_h", 32'(d), 32'h3F);

    // Flush on the same edge as a peak push
    send_byte(8'h01);
    @(negedge clk);
    rx_data = 8'h03; rx_valid = 1'b1;
    peak_valid = 1'b1; peak_location = 22'h012345;
    @(posedge clk); #1;
    rx_valid = 1'b0; peak_valid = 1'b0;
    read_reg(3'd1, d); chk("sr_flush_wins", 32'(d), 32'h4A);

    // Malformed command is dropped silently
    r0 = resp_cnt;
    send_byte(8'hF3);
    repeat (3) @(negedge clk);
    chk("f3_no_resp", 32'(tx_valid), 32'd0);
    read_reg(3'd1, d); chk("sr_after_f3", 32'(d), 32'h4A);
    chk("one_response", 32'(resp_cnt - r0), 32'd1);

    // Reserved address
    write_reg(3'd7, 8'hFF);
    read_reg(3'd7, d); chk("reserved_read", 32'(d), 32'h00);
    read_reg(3'd1, d); chk("sr_after_reserved", 32'(d), 32'h4A);

    // Reset while a response is pending
    send_byte(8'h02);
    chk("resp_pending", 32'(tx_valid), 32'd1);
    do_reset();
    chk("abort_tx_valid", 32'(tx_valid), 32'd0);
    chk("abort_rx_ready", 32'(rx_ready), 32'd1);
    chk("abort_ce", 32'(ce), 32'd0);
    read_reg(3'd1, d); chk("sr_after_abort", 32'(d), 32'h0A);

`ifdef UART_BRIDGE_TIMEOUT_EN
    write_reg(3'd2, 8'h55);
    send_byte(8'h05);
    repeat (150) @(negedge clk);
    read_reg(3'd1, d); chk("sr_timeout", 32'(d), 32'h8A);
    read_reg(3'd2, d); chk("dinl_kept", 32'(d), 32'h55);
    write_reg(3'd0, 8'h02);
    read_reg(3'd1, d); chk("sr_timeout_cleared", 32'(d), 32'h0A);
`else
    send_byte(8'h05);
    repeat (150) @(negedge clk);
    chk("wdata_wait_rx_ready", 32'(rx_ready), 32'd1);
    chk("wdata_wait_tx_valid", 32'(tx_valid), 32'd0);
    send_byte(8'h77);
    read_reg(3'd2, d); chk("dinl_late", 32'(d), 32'h77);
    read_reg(3'd1, d); chk("sr_no_timeout", 32'(d), 32'h0A);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
